// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Brief    : Shared types, constants and helpers for the two-way ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    localparam int W      = 16;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_XOR = 3'd2,
        OP_RED = 3'd3
    } alu_opcode_e;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_is_illegal(input logic [2:0] op);
        return op[2];
    endfunction

    // ADD/SUB refresh all three flags; logic ops only refresh Z.
    function automatic logic [2:0] merge_flags(input logic [2:0] op,
                                               input logic [2:0] cur,
                                               input logic [2:0] alu);
        logic [2:0] res;
        res = cur;
        if (op_is_arith(op)) begin
            res = alu;
        end else begin
            res[FLAG_Z] = alu[FLAG_Z];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arb
// Brief    : Combinational two-way round-robin arbiter; pointer lives in parent.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arb (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);
    import alu_arb_pkg::*;

    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one external ALU between two requesters (round robin),
//            returns tagged responses and keeps per-requester flags.
// Options  : define ALU_ARB_STAT_EN to add sat_cnt0/sat_cnt1 overflow counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int ALU_LAT = 0,
    parameter int W       = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic [2:0]   flags0,
    output logic [2:0]   flags1,
    output logic [W-1:0] alu_in1,
    output logic [W-1:0] alu_in2,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_out,
    input  logic [2:0]   alu_flags,
    input  logic         alu_error
`ifdef ALU_ARB_STAT_EN
    ,
    output logic [15:0]  sat_cnt0,
    output logic [15:0]  sat_cnt1
`endif
);
    import alu_arb_pkg::*;

    localparam logic [1:0] c_ALU_LAT = 2'(ALU_LAT);

    logic [1:0]   r_state_q,      w_state_d;
    logic [1:0]   r_cnt_q,        w_cnt_d;
    logic         r_last_grant_q, w_last_grant_d;
    logic         r_op_id_q,      w_op_id_d;
    logic [2:0]   r_op_code_q,    w_op_code_d;
    logic [W-1:0] r_op_a_q,       w_op_a_d;
    logic [W-1:0] r_op_b_q,       w_op_b_d;
    logic         r_rsp_id_q,     w_rsp_id_d;
    logic [W-1:0] r_rsp_data_q,   w_rsp_data_d;
    logic         r_rsp_err_q,    w_rsp_err_d;
    logic [2:0]   r_flags0_q,     w_flags0_d;
    logic [2:0]   r_flags1_q,     w_flags1_d;
    logic [1:0]   w_grant;
    logic         w_capture;
    logic         w_err;

    alu_rr_arb u_arb (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant_q),
        .o_grant      (w_grant)
    );

    // Grants are only offered from IDLE and never while reset is held.
    assign req0_ready = ~rst & (r_state_q == IDLE) & w_grant[0];
    assign req1_ready = ~rst & (r_state_q == IDLE) & w_grant[1];

    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_last_grant_d = r_last_grant_q;
        w_op_id_d      = r_op_id_q;
        w_op_code_d    = r_op_code_q;
        w_op_a_d       = r_op_a_q;
        w_op_b_d       = r_op_b_q;
        w_capture      = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (|w_grant) begin
                    w_op_id_d      = w_grant[1];
                    w_op_code_d    = w_grant[1] ? req1_op : req0_op;
                    w_op_a_d       = w_grant[1] ? req1_a  : req0_a;
                    w_op_b_d       = w_grant[1] ? req1_b  : req0_b;
                    w_last_grant_d = w_grant[1];
                    w_cnt_d        = c_ALU_LAT;
                    w_state_d      = EXEC;
                end
            end
            EXEC: begin
                if (r_cnt_q == 2'd0) begin
                    w_capture = 1'b1;
                    w_state_d = RESP;
                end else begin
                    w_cnt_d = r_cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_err        = alu_error | op_is_illegal(r_op_code_q);
        w_rsp_id_d   = r_rsp_id_q;
        w_rsp_data_d = r_rsp_data_q;
        w_rsp_err_d  = r_rsp_err_q;
        w_flags0_d   = r_flags0_q;
        w_flags1_d   = r_flags1_q;
        if (w_capture) begin
            w_rsp_id_d   = r_op_id_q;
            w_rsp_data_d = alu_out;
            w_rsp_err_d  = w_err;
            // A failed operation leaves the requester's flags untouched.
            if (!w_err) begin
                if (r_op_id_q) begin
                    w_flags1_d = merge_flags(r_op_code_q, r_flags1_q, alu_flags);
                end else begin
                    w_flags0_d = merge_flags(r_op_code_q, r_flags0_q, alu_flags);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= IDLE;
            r_cnt_q        <= 2'd0;
            r_last_grant_q <= 1'b1;
            r_op_id_q      <= 1'b0;
            r_op_code_q    <= 3'd0;
            r_op_a_q       <= '0;
            r_op_b_q       <= '0;
            r_rsp_id_q     <= 1'b0;
            r_rsp_data_q   <= '0;
            r_rsp_err_q    <= 1'b0;
            r_flags0_q     <= 3'd0;
            r_flags1_q     <= 3'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_last_grant_q <= w_last_grant_d;
            r_op_id_q      <= w_op_id_d;
            r_op_code_q    <= w_op_code_d;
            r_op_a_q       <= w_op_a_d;
            r_op_b_q       <= w_op_b_d;
            r_rsp_id_q     <= w_rsp_id_d;
            r_rsp_data_q   <= w_rsp_data_d;
            r_rsp_err_q    <= w_rsp_err_d;
            r_flags0_q     <= w_flags0_d;
            r_flags1_q     <= w_flags1_d;
        end
    end

    assign rsp_valid = (r_state_q == RESP);
    assign rsp_id    = r_rsp_id_q;
    assign rsp_data  = r_rsp_data_q;
    assign rsp_err   = r_rsp_err_q;
    assign flags0    = r_flags0_q;
    assign flags1    = r_flags1_q;
    assign alu_in1   = r_op_a_q;
    assign alu_in2   = r_op_b_q;
    assign alu_op    = r_op_code_q;

`ifdef ALU_ARB_STAT_EN
    logic [15:0] r_sat_cnt0_q, w_sat_cnt0_d;
    logic [15:0] r_sat_cnt1_q, w_sat_cnt1_d;
    logic        w_sat_hit;

    always_comb begin
        w_sat_hit    = w_capture & op_is_arith(r_op_code_q) & alu_flags[FLAG_V];
        w_sat_cnt0_d = r_sat_cnt0_q;
        w_sat_cnt1_d = r_sat_cnt1_q;
        if (w_sat_hit && !r_op_id_q && (r_sat_cnt0_q != 16'hFFFF)) begin
            w_sat_cnt0_d = r_sat_cnt0_q + 16'd1;
        end
        if (w_sat_hit && r_op_id_q && (r_sat_cnt1_q != 16'hFFFF)) begin
            w_sat_cnt1_d = r_sat_cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_cnt0_q <= 16'd0;
            r_sat_cnt1_q <= 16'd0;
        end else begin
            r_sat_cnt0_q <= w_sat_cnt0_d;
            r_sat_cnt1_q <= w_sat_cnt1_d;
        end
    end

    assign sat_cnt0 = r_sat_cnt0_q;
    assign sat_cnt1 = r_sat_cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against a transaction-level model of arbitration and flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
    logic [15:0] rsp_data, alu_in1, alu_in2, alu_out;
    logic [2:0]  flags0, flags1, alu_op, alu_flags;
    logic        alu_error;

    logic        v3_0, v3_1, rr3;
    logic        req0_ready_3, req1_ready_3, rsp_valid_3, rsp_id_3, rsp_err_3;
    logic [15:0] rsp_data_3, alu_in1_3, alu_in2_3, alu_out_3;
    logic [2:0]  flags0_3, flags1_3, alu_op_3, alu_flags_3;
    logic        alu_error_3;

    int          checks;
    int          failures;
    logic [2:0]  m_flags [2];
    logic        m_last;

    // External saturating ALU: returns {error, Z, V, N, result}.
    function automatic logic [19:0] alu_model(input logic [2:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        logic [15:0] r;
        logic [16:0] t;
        logic        v;
        logic        e;
        r = 16'h0;
        t = 17'h0;
        v = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                t = (op == 3'd0) ? ({a[15], a} + {b[15], b}) : ({a[15], a} - {b[15], b});
                if (t[16] != t[15]) begin
                    v = 1'b1;
                    r = a[15] ? 16'h8000 : 16'h7FFF;
                end else begin
                    r = t[15:0];
                end
            end
            3'd2:    r = a ^ b;
            3'd3:    r = 16'($countones(a) + $countones(b));
            default: r = 16'h0;
        endcase
        e = (op < 3'd4) && (a[3:0] == 4'hE);
        return {e, (r == 16'h0), v, r[15], r};
    endfunction

    logic [19:0] alu_res, alu_res_3;
    assign alu_res     = alu_model(alu_op, alu_in1, alu_in2);
    assign alu_out     = alu_res[15:0];
    assign alu_flags   = alu_res[18:16];
    assign alu_error   = alu_res[19];
    assign alu_res_3   = alu_model(alu_op_3, alu_in1_3, alu_in2_3);
    assign alu_out_3   = alu_res_3[15:0];
    assign alu_flags_3 = alu_res_3[18:16];
    assign alu_error_3 = alu_res_3[19];

    alu_arbiter #(.ALU_LAT(0), .W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flags0(flags0), .flags1(flags1),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_flags(alu_flags), .alu_error(alu_error)
    );

    alu_arbiter #(.ALU_LAT(3), .W(16)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(v3_0), .req0_ready(req0_ready_3), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(v3_1), .req1_ready(req1_ready_3), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid_3), .rsp_ready(rr3), .rsp_id(rsp_id_3),
        .rsp_data(rsp_data_3), .rsp_err(rsp_err_3),
        .flags0(flags0_3), .flags1(flags1_3),
        .alu_in1(alu_in1_3), .alu_in2(alu_in2_3), .alu_op(alu_op_3),
        .alu_out(alu_out_3), .alu_flags(alu_flags_3), .alu_error(alu_error_3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: expected result/error of one accepted op, updating flag state.
    task automatic model_exec(input logic id, input logic [2:0] op,
                              input logic [15:0] a, input logic [15:0] b,
                              output logic [15:0] d, output logic e);
        logic [19:0] r;
        r = alu_model(op, a, b);
        d = r[15:0];
        e = r[19] || (op > 3'd3);
        if (!e) begin
            if (op <= 3'd1) m_flags[id] = r[18:16];
            else            m_flags[id][2] = r[18];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        v3_0 = 1'b0; v3_1 = 1'b0; rr3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_flags[0] = 3'd0; m_flags[1] = 3'd0; m_last = 1'b1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_id_err: got %b %b expected 0 0", rsp_id, rsp_err); end
        checks++; if (rsp_data !== 16'h0) begin failures++; $display("FAIL reset_data: got %h expected 0000", rsp_data); end
        checks++; if (flags0 !== 3'd0 || flags1 !== 3'd0) begin failures++; $display("FAIL reset_flags: got %b %b expected 000 000", flags0, flags1); end
        checks++; if (alu_in1 !== 16'h0 || alu_in2 !== 16'h0 || alu_op !== 3'd0) begin failures++; $display("FAIL reset_alu: got %h %h %h expected 0 0 0", alu_in1, alu_in2, alu_op); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_flags[0] = 3'd0; m_flags[1] = 3'd0; m_last = 1'b1;
    endtask

    task automatic test_add_latency();
        int n;
        logic [15:0] d;
        logic e;
        req0_op = 3'd0; req0_a = 16'h7000; req0_b = 16'h2000; req0_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL add_ready: got %b%b expected 01", req1_ready, req0_ready); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        model_exec(1'b0, 3'd0, 16'h7000, 16'h2000, d, e);
        wait_rsp(n);
        checks++; if (n != 1) begin failures++; $display("FAIL add_latency: got %0d edges expected 1", n); end
        checks++; if (rsp_data !== 16'h7FFF || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin failures++; $display("FAIL add_rsp: got %h id %b err %b expected 7fff id 0 err 0", rsp_data, rsp_id, rsp_err); end
        checks++; if (flags0 !== 3'b010 || flags1 !== 3'b000) begin failures++; $display("FAIL add_flags: got %b %b expected 010 000", flags0, flags1); end
        consume();
    endtask

    task automatic test_both_valid();
        int n;
        logic [15:0] d;
        logic e;
        do_reset();
        req0_op = 3'd1; req0_a = 16'h8000; req0_b = 16'h0001;
        req1_op = 3'd2; req1_a = 16'h00FF; req1_b = 16'h00FF;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL both_first_grant: got r1r0=%b%b expected 01", req1_ready, req0_ready); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        model_exec(1'b0, 3'd1, 16'h8000, 16'h0001, d, e);
        wait_rsp(n);
        checks++; if (rsp_data !== 16'h8000 || rsp_id !== 1'b0 || flags0 !== 3'b011) begin failures++; $display("FAIL both_req0: got %h id %b flags0 %b expected 8000 id 0 flags0 011", rsp_data, rsp_id, flags0); end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL both_no_grant_in_rsp: got %b expected 0", req1_ready); end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL both_second_grant: got %b expected 1", req1_ready); end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        model_exec(1'b1, 3'd2, 16'h00FF, 16'h00FF, d, e);
        wait_rsp(n);
        checks++; if (rsp_data !== 16'h0000 || rsp_id !== 1'b1 || flags1 !== 3'b100 || flags0 !== 3'b011) begin failures++; $display("FAIL both_req1: got %h id %b flags1 %b flags0 %b expected 0000 id 1 100 011", rsp_data, rsp_id, flags1, flags0); end
        consume();
    endtask

    task automatic test_red();
        int n;
        req1_op = 3'd3; req1_a = 16'h0101; req1_b = 16'h0101; req1_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(n);
        checks++; if (rsp_data !== 16'h0004 || rsp_err !== 1'b0 || rsp_id !== 1'b1) begin failures++; $display("FAIL red_rsp: got %h err %b id %b expected 0004 err 0 id 1", rsp_data, rsp_err, rsp_id); end
        checks++; if (flags1 !== 3'b000 || flags0 !== 3'b011) begin failures++; $display("FAIL red_flags: got %b %b expected 000 011", flags1, flags0); end
        consume();
    endtask

    task automatic test_illegal();
        int n;
        req0_op = 3'd5; req0_a = 16'h1234; req0_b = 16'h0001; req0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp(n);
        checks++; if (rsp_err !== 1'b1 || rsp_id !== 1'b0) begin failures++; $display("FAIL illegal_err: got err %b id %b expected err 1 id 0", rsp_err, rsp_id); end
        checks++; if (flags0 !== 3'b011) begin failures++; $display("FAIL illegal_flags: got %b expected 011", flags0); end
        consume();
    endtask

    task automatic test_backpressure();
        int n;
        logic [15:0] sd;
        logic si, se;
        req0_op = 3'd2; req0_a = 16'h0005; req0_b = 16'h0003; req0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp(n);
        sd = rsp_data; si = rsp_id; se = rsp_err;
        checks++; if (sd !== 16'h0006) begin failures++; $display("FAIL bp_data: got %h expected 0006", sd); end
        req1_op = 3'd0; req1_a = 16'h0010; req1_b = 16'h0020; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== sd || rsp_id !== si || rsp_err !== se || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: got v%b %h id%b err%b rdy1 %b expected v1 %h id%b err%b rdy1 0", i, rsp_valid, rsp_data, rsp_id, rsp_err, req1_ready, sd, si, se);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL bp_handshake_grant: got %b expected 0", req1_ready); end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL bp_next_grant: got %b expected 1", req1_ready); end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(n);
        checks++; if (rsp_data !== 16'h0030 || rsp_id !== 1'b1) begin failures++; $display("FAIL bp_req1_rsp: got %h id %b expected 0030 id 1", rsp_data, rsp_id); end
        consume();
    endtask

    task automatic test_random();
        int n, pat, stall;
        logic w;
        logic [2:0] o0, o1;
        logic [15:0] a0, b0, a1, b1, d;
        logic e;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            pat = $urandom_range(1, 3);
            o0 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            o1 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            a0 = 16'($urandom); b0 = 16'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b0 = a0;
            req0_op = o0; req0_a = a0; req0_b = b0;
            req1_op = o1; req1_a = a1; req1_b = b1;
            req0_valid = (pat != 2); req1_valid = (pat != 1);
            w = (pat == 1) ? 1'b0 : (pat == 2) ? 1'b1 : !m_last;
            #1;
            checks++; if (req0_ready !== !w || req1_ready !== w) begin failures++; $display("FAIL rnd_grant it %0d: got r1r0=%b%b expected winner %0d", it, req1_ready, req0_ready, w); end
            @(posedge clk);
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            m_last = w;
            if (w) model_exec(1'b1, o1, a1, b1, d, e);
            else   model_exec(1'b0, o0, a0, b0, d, e);
            wait_rsp(n);
            checks++; if (n != 1) begin failures++; $display("FAIL rnd_latency it %0d: got %0d expected 1", it, n); end
            stall = $urandom_range(0, 2);
            repeat (stall) @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_id !== w || rsp_err !== e) begin
                failures++;
                $display("FAIL rnd_rsp it %0d: got v%b %h id%b err%b expected v1 %h id%b err%b", it, rsp_valid, rsp_data, rsp_id, rsp_err, d, w, e);
            end
            checks++;
            if (flags0 !== m_flags[0] || flags1 !== m_flags[1]) begin
                failures++;
                $display("FAIL rnd_flags it %0d: got %b %b expected %b %b", it, flags0, flags1, m_flags[0], m_flags[1]);
            end
            consume();
        end
    endtask

    task automatic test_reset_exec();
        bit seen;
        do_reset();
        req0_op = 3'd0; req0_a = 16'h1111; req0_b = 16'h2222; v3_0 = 1'b1;
        #1;
        checks++; if (req0_ready_3 !== 1'b1) begin failures++; $display("FAIL lat3_ready: got %b expected 1", req0_ready_3); end
        @(posedge clk);
        @(negedge clk);
        v3_0 = 1'b0;
        checks++; if (alu_op_3 !== 3'd0 || alu_in1_3 !== 16'h1111 || alu_in2_3 !== 16'h2222 || rsp_valid_3 !== 1'b0) begin failures++; $display("FAIL lat3_exec_drive: got op %h %h %h v%b expected 0 1111 2222 v0", alu_op_3, alu_in1_3, alu_in2_3, rsp_valid_3); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid_3 !== 1'b0 || rsp_id_3 !== 1'b0 || rsp_data_3 !== 16'h0 || rsp_err_3 !== 1'b0 ||
            flags0_3 !== 3'd0 || flags1_3 !== 3'd0 || alu_in1_3 !== 16'h0 || alu_in2_3 !== 16'h0 ||
            alu_op_3 !== 3'd0 || req0_ready_3 !== 1'b0 || req1_ready_3 !== 1'b0) begin
            failures++;
            $display("FAIL lat3_async_reset: got v%b id%b %h err%b in1 %h in2 %h op %h expected all zero", rsp_valid_3, rsp_id_3, rsp_data_3, rsp_err_3, alu_in1_3, alu_in2_3, alu_op_3);
        end
        @(negedge clk);
        rst = 1'b0; rr3 = 1'b1;
        m_flags[0] = 3'd0; m_flags[1] = 3'd0; m_last = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid_3 === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL lat3_discarded: got response %b expected none", seen); end
        rr3 = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_op = 3'd0; req0_a = 16'h0; req0_b = 16'h0;
        req1_op = 3'd0; req1_a = 16'h0; req1_b = 16'h0;
        v3_0 = 1'b0; v3_1 = 1'b0; rr3 = 1'b0;
        m_flags[0] = 3'd0; m_flags[1] = 3'd0; m_last = 1'b1;
        test_reset();
        test_add_latency();
        test_both_valid();
        test_red();
        test_illegal();
        test_backpressure();
        test_random();
        test_reset_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one 16-bit ALU (ADD/SUB saturating, XOR, RED; Error output; Flags {Z,V,N}) between two requesters using a round-robin grant. Accepts one operation at a time with a valid/ready handshake and sequences it through the ALU over a configurable latency. It returns the result on a single response channel tagged with the requester ID and keeps a separate flag register per requester. The block sits between the issue logic of two execution contexts and the shared ALU instance.

Parameters:
ALU_LAT, 0, extra ALU cycles before the result is valid (0 = combinational ALU; legal range 0..3)
W, 16, operand/result width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  3  opcode (0 ADD, 1 SUB, 2 XOR, 3 RED; 4-7 illegal)
req0_a, req0_b  in  W  operands
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as above, requester 1
rsp_valid  out  1  response held
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester that issued the response
rsp_data  out  W  ALU result
rsp_err  out  1  ALU Error or illegal opcode
flags0, flags1  out  3  per-requester flags {Z,V,N} = [2],[1],[0]
alu_in1, alu_in2  out  W  to shared ALU
alu_op  out  3  to shared ALU
alu_out  in  W  from ALU
alu_flags  in  3  from ALU {Z,V,N}
alu_error  in  1  from ALU

Behaviour:
- Reset: state IDLE; req*_ready=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_err=0; flags0=flags1=0; alu_in1/in2/op=0; last_grant=1, so requester 0 wins first.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req valid, grant: a single valid requester wins; if both are valid, the winner is !last_grant.
  - The granted reqN_ready is asserted combinationally in the same cycle. Operands, opcode and ID are latched into the op registers at the edge.
  - last_grant <= winner; cnt <= ALU_LAT; go to EXEC.
  - ready is never asserted outside IDLE. Both readys are never high together.
- EXEC:
  - alu_in1/alu_in2/alu_op are driven from the op registers and are stable for the whole EXEC.
  - If cnt==0: capture rsp_data<=alu_out, rsp_err<=alu_error | (op>3), rsp_id<=ID, update flags; go to RESP. Otherwise cnt--.
- Latency: handshake at edge k, rsp_valid high after edge k+1+ALU_LAT.
- RESP:
  - rsp_valid=1. rsp_data, rsp_id and rsp_err stay constant until the cycle with rsp_valid&rsp_ready; the FSM then goes to IDLE.
  - No new grant is made in the handshake cycle. Throughput is one op per ALU_LAT+3 cycles.
- Flag update, applied to flags[ID] only:
  - ADD/SUB: Z, V, N all take the ALU value.
  - XOR/RED: Z only.
  - Error: no update.
  - The other requester's flags never change.
- The block does not recompute results; saturation and RED sign extension belong to the ALU.
- Requests whose valid drops before the grant are not accepted; no queuing.
- rst asserted in any state returns immediately to the reset values. An in-flight op is discarded and produces no response.

Optional Feature:
ALU_ARB_STAT_EN:
- Defined: adds outputs sat_cnt0 and sat_cnt1 (16 bits each). Each increments on a capture of ADD/SUB with alu_flags[1]=1 for that ID, saturates at 0xFFFF, and is cleared by rst.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg holds:
  - opcode enum (ADD=0, SUB=1, XOR=2, RED=3)
  - state enum (IDLE, EXEC, RESP)
  - flag index constants FLAG_Z=2, FLAG_V=1, FLAG_N=0
  - width constant W=16
- Sub-module alu_rr_arb: 2-way round-robin arbiter (valids, last_grant in; grant one-hot out). It is combinational; the pointer register stays in the top.

Test Plan:
- ALU_LAT=0, req0 ADD 0x7000+0x2000 -> rsp_valid 2 cycles after accept; rsp_data=0x7FFF; id=0; flags0=3'b010; flags1 unchanged at 0.
- Both valid at once, req0 SUB 0x8000-0x0001 and req1 XOR 0x00FF^0x00FF -> req0 served first with data 0x8000 and flags0=3'b011. req1 served next with data 0x0000; flags1[Z]=1, V/N stay 0.
- req1 RED 0x0101,0x0101 -> rsp_data=0x0004, rsp_err=0, only flags1[Z] written (0).
- req0 op=5 -> rsp_err=1; flags0 unchanged.
- Backpressure: hold rsp_ready=0 for 10 cycles while req1 is valid -> rsp fields stable, req1_ready=0 throughout. After rsp_ready, req1 is granted in the following IDLE cycle.
- ALU_LAT=3, assert rst during EXEC -> all outputs at reset values next cycle, and no response is ever produced for that op.
